// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and types for the FIFO read-side stream engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_RD_LAT = 1;
    localparam int SKID_DEPTH  = 3;

    typedef logic [1:0] skid_ptr_t;
    typedef logic [1:0] skid_occ_t;

    // Circular pointer advance over a non-power-of-two depth.
    function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
// Module   : stream_skid_buf
// Brief    : Three-entry circular buffer with push/pop and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output skid_occ_t         occ
);

    logic [DATA_W-1:0] r_mem [SKID_DEPTH];
    skid_ptr_t         r_head;
    skid_ptr_t         r_tail;
    skid_occ_t         r_occ;
    logic              w_push;
    logic              w_pop;

    // A push into a full buffer is only legal when the head leaves the same edge.
    assign w_pop  = pop && (r_occ != '0);
    assign w_push = push && ((r_occ != skid_occ_t'(SKID_DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + skid_occ_t'(1);
                2'b01:   r_occ <= r_occ - skid_occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign valid = (r_occ != '0);
    assign data  = r_mem[r_head];
    assign occ   = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Drains a single-clock FIFO into a valid/ready stream via a skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_w,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rde,
    input  logic [DATA_W-1:0] fifo_rdd,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              idle
);

    logic [FIFO_RD_LAT-1:0] r_rd_pipe;
    logic [CNT_W-1:0]       r_rd_count;
    skid_occ_t              w_occ;
    logic                   w_rde;
    logic                   w_capture;
    logic                   w_pop;
    int                     w_pending;

    // Reads already issued count against buffer space, so the buffer cannot overflow.
    always_comb begin
        w_pending = int'(w_occ) + $countones(r_rd_pipe);
        w_rde     = en && !fifo_empty && (w_pending < SKID_DEPTH);
    end

    assign w_capture = r_rd_pipe[FIFO_RD_LAT-1];
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk_w or posedge reset) begin
        if (reset) begin
            r_rd_pipe  <= '0;
            r_rd_count <= '0;
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1) | FIFO_RD_LAT'(w_rde);
            if (w_pop) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk_w),
        .rst       (reset),
        .push      (w_capture),
        .push_data (fifo_rdd),
        .pop       (w_pop),
        .valid     (out_valid),
        .data      (out_data),
        .occ       (w_occ)
    );

    assign fifo_rde = w_rde;
    assign rd_count = r_rd_count;
    assign idle     = (w_occ == '0) && (r_rd_pipe == '0);

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Directed self-checking bench with a stub FIFO for fifo_rd_stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    logic       clk_w = 1'b0;
    logic       reset;
    logic       en;
    logic       fifo_empty;
    logic       fifo_rde;
    logic [7:0] fifo_rdd;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] rd_count;
    logic       idle;

    int checks   = 0;
    int errors   = 0;
    int rde_viol = 0;
    int pulses;

    logic [7:0] stub_mem [64];
    int         stub_wr = 0;
    int         stub_rd = 0;
    logic [7:0] got [$];

    always #5 clk_w = ~clk_w;

    fifo_rd_stream #(
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk_w      (clk_w),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rde   (fifo_rde),
        .fifo_rdd   (fifo_rdd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .rd_count   (rd_count),
        .idle       (idle)
    );

    // Stub FIFO: data appears one cycle after the strobe; reset discards contents.
    assign fifo_empty = (stub_rd == stub_wr);

    always @(posedge clk_w or posedge reset) begin
        if (reset) begin
            stub_rd  <= stub_wr;
            fifo_rdd <= 8'h00;
        end else if (fifo_rde) begin
            fifo_rdd <= stub_mem[stub_rd % 64];
            stub_rd  <= stub_rd + 1;
        end
    end

    always @(posedge clk_w) begin
        if (!reset) begin
            assert (!(fifo_rde && fifo_empty)) else begin
                rde_viol++;
                $error("FAIL rde_while_empty observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        stub_mem[stub_wr % 64] = v;
        stub_wr = stub_wr + 1;
    endtask

    task automatic push4();
        push(8'hA5); push(8'hAA); push(8'hAF); push(8'hB4);
    endtask

    task automatic tick();
        @(negedge clk_w);
    endtask

    // Records every accepted word until n words are seen or the budget expires.
    task automatic collect(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            if (got.size() == n) break;
            @(negedge clk_w);
        end
    endtask

    initial begin
        logic [7:0] t1_dat [7];
        logic       t1_rde [7];
        logic       t1_val [7];
        t1_rde = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t1_val = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t1_dat = '{8'h00, 8'h00, 8'hA5, 8'hAA, 8'hAF, 8'hB4, 8'h00};

        reset = 1'b1; en = 1'b0; out_ready = 1'b0;
        tick(); #1;
        chk("rst_rde", fifo_rde, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_idle", idle, 1);
        tick(); reset = 1'b0;

        // Streaming at full rate
        push4();
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin en = 1'b1; out_ready = 1'b1; end
            #1;
            chk($sformatf("t1_rde_c%0d", i), fifo_rde, t1_rde[i]);
            chk($sformatf("t1_valid_c%0d", i), out_valid, t1_val[i]);
            if (t1_val[i]) chk($sformatf("t1_data_c%0d", i), out_data, t1_dat[i]);
        end
        chk("t1_count", rd_count, 4);
        chk("t1_idle", idle, 1);

        // Back-pressure
        tick(); en = 1'b0; out_ready = 1'b0; push4();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) en = 1'b1;
            #1;
            if (fifo_rde) pulses++;
        end
        chk("t2_rde_pulses", pulses, 3);
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_data", out_data, 8'hA5);
        chk("t2_hold_count", rd_count, 4);
        tick(); out_ready = 1'b1;
        got.delete();
        collect(4, 20);
        chk("t2_nwords", got.size(), 4);
        chk("t2_w0", got[0], 8'hA5);
        chk("t2_w1", got[1], 8'hAA);
        chk("t2_w2", got[2], 8'hAF);
        chk("t2_w3", got[3], 8'hB4);
        tick(); #1;
        chk("t2_count", rd_count, 8);
        chk("t2_idle", idle, 1);

        // Enable dropped after first strobe
        tick(); en = 1'b0; push4();
        tick(); en = 1'b1; #1;
        chk("t3_rde_first", fifo_rde, 1);
        tick(); en = 1'b0; #1;
        chk("t3_rde_stop", fifo_rde, 0);
        got.delete();
        collect(2, 6);
        chk("t3_nwords", got.size(), 1);
        chk("t3_w0", got[0], 8'hA5);
        #1;
        chk("t3_idle", idle, 1);
        chk("t3_count", rd_count, 9);
        chk("t3_rde_off", fifo_rde, 0);
        en = 1'b1;
        got.delete();
        collect(3, 20);
        chk("t3_nwords_re", got.size(), 3);
        chk("t3_w1", got[0], 8'hAA);
        chk("t3_w2", got[1], 8'hAF);
        chk("t3_w3", got[2], 8'hB4);
        tick(); #1;
        chk("t3_count_re", rd_count, 12);

        // Reset with two buffered words and one read in flight
        tick(); en = 1'b0; out_ready = 1'b0; push4();
        tick(); en = 1'b1;
        tick(); tick(); tick(); #1;
        chk("t4_pre_idle", idle, 0);
        chk("t4_pre_valid", out_valid, 1);
        reset = 1'b1; #1;
        chk("t4_rst_rde", fifo_rde, 0);
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_data", out_data, 0);
        chk("t4_rst_count", rd_count, 0);
        chk("t4_rst_idle", idle, 1);
        tick(); en = 1'b0;
        tick(); reset = 1'b0;
        push(8'h3C); en = 1'b1; out_ready = 1'b1; #1;
        chk("t4_rde_3c", fifo_rde, 1);
        tick(); #1;
        chk("t4_lat_valid1", out_valid, 0);
        tick(); #1;
        chk("t4_lat_valid2", out_valid, 1);
        chk("t4_data_3c", out_data, 8'h3C);
        tick(); #1;
        chk("t4_count", rd_count, 1);
        chk("t4_idle", idle, 1);

        // Counter wrap with 17 words
        tick(); en = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        en = 1'b1;
        got.delete();
        collect(17, 60);
        chk("t5_nwords", got.size(), 17);
        for (int i = 0; i < 17; i++) chk($sformatf("t5_w%0d", i), got[i], 8'(8'h10 + i));
        tick(); #1;
        chk("t5_count_wrap", rd_count, 1);
        chk("t5_idle", idle, 1);
        chk("rde_never_empty", rde_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the team's single-clock byte FIFO.
- Watches the FIFO `empty` flag, issues `rde` pulses, captures `rdd` one cycle later, and presents the words on a valid/ready output stream.
- An internal 3-entry skid buffer sustains one word per cycle with no combinational path from `out_ready` to `fifo_rde`.
- Sits between the FIFO read port and any downstream consumer (serializer, ALU operand loader).

Parameters:
- DATA_W, 8, width of FIFO words and output data.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk_w  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  enables issuing new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rde  out  1  FIFO read strobe, one word per high cycle.
- fifo_rdd  in  DATA_W  FIFO read data, valid exactly 1 cycle after fifo_rde.
- out_valid  out  1  output word available.
- out_data  out  DATA_W  output word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- rd_count  out  CNT_W  number of words delivered, modulo 2^CNT_W.
- idle  out  1  high when buffer is empty and no read is in flight.

Behaviour:
- Interface: one clock, clk_w; reset is asynchronous and active-high (port `reset`).
- Reset values:
  - fifo_rde=0, out_valid=0, out_data=0, rd_count=0, idle=1.
  - Internal occ=0, inflight=0, buffer pointers=0.
- State:
  - occ (0..3): buffered words.
  - inflight (0/1): registered copy of the previous cycle's fifo_rde.
- Issue rule (combinational from registers, en, fifo_empty only):
  - fifo_rde = en && !fifo_empty && (occ + inflight < 3).
  - Never assert fifo_rde while fifo_empty=1.
- Capture: if inflight=1 at an edge, fifo_rdd is written to the buffer tail at that edge.
- Pop: out_valid && out_ready at an edge removes the head word and increments rd_count.
  - rd_count wraps from 2^CNT_W-1 to 0.
- Simultaneous capture and pop: occ is unchanged and head/tail both advance.
  - A capture into an empty buffer appears on out_data the next cycle; there is no bypass.
- Latency: the first word reaches out_valid 2 cycles after its fifo_rde cycle.
- Throughput: 1 word/cycle in steady state with out_ready held high.
- Back-pressure:
  - With out_ready=0, at most 3 words are read beyond the consumer.
  - The buffer never overflows, because the issue rule accounts for inflight.
- out_data/out_valid hold stable while out_valid && !out_ready.
- en deassert: stops new fifo_rde immediately. An in-flight word is still captured and buffered words still drain.
- FIFO becomes empty mid-burst: fifo_rde drops the same cycle. Already-issued reads complete normally.
- idle = (occ==0) && (inflight==0).
- Reset mid-operation: all state clears asynchronously and in-flight data is discarded. After release, the first fifo_rde may occur on the first edge.
- Buffer pointers are 2-bit and wrap 2->0.

Decomposition:
- fifo_pkg (shared):
  - DATA_W default = 8.
  - FIFO_RD_LAT = 1.
  - SKID_DEPTH = 3.
- One sub-module, stream_skid_buf: 3-entry circular buffer with push/pop/occ, instantiated once.
- Issue logic and the counter stay in the top module.

Test Plan:
- Reset while idle: fifo_rde=0, out_valid=0, rd_count=0, idle=1.
- Stub FIFO preloaded A5,AA,AF,B4; en=1; out_ready=1:
  - fifo_rde high 4 consecutive cycles.
  - out_data A5,AA,AF,B4 on consecutive cycles starting 2 cycles after the first rde.
  - rd_count=4, idle=1 at end.
- Same preload, out_ready=0 for 10 cycles:
  - Exactly 3 rde pulses; out_valid=1 with out_data=A5 held.
  - After out_ready=1, all 4 words arrive in order with none lost.
- en dropped the cycle after the first rde: only A5 is delivered and idle=1.
  - Re-asserting en delivers AA,AF,B4.
- Reset asserted with occ=2 and inflight=1: all outputs return to reset values within the same cycle.
  - The stub FIFO also resets; the next push of 3C is delivered as the first word.
- CNT_W=4, 17 words: rd_count reads 1 after wrap. fifo_rde never asserted while fifo_empty=1 (assertion).
